// File: rtl/button_pkg.sv
// button_pkg: shared definitions for the push-button conditioner.
//   - btn_state_e : per-channel debounce FSM state
//   - cnt_width() : width of the saturating debounce/repeat counters
//   - *_DEF       : default parameter values used by the top and interface
package button_pkg;

  localparam int N_BTN_DEF           = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 20;
  localparam int REPEAT_DELAY_DEF    = 500;
  localparam int REPEAT_PERIOD_DEF   = 100;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // ceil(log2(max(a, b, c))) + 1: always wide enough to hold the largest
  // threshold itself, so a saturated counter can sit at that value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: button bundle between the board-side driver and the
// conditioner.
//   BUTTONS_RAW   : raw active-high pin levels (asynchronous to CLK)
//   BUTTONS       : one-cycle press pulse per channel
//   BUTTONS_LEVEL : debounced held level per channel
// Modports: master drives the raw levels, slave (the conditioner) drives the
// conditioned outputs.
interface button_conditioner_if
  import button_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF
);
  logic [N_BTN-1:0] BUTTONS_RAW;
  logic [N_BTN-1:0] BUTTONS;
  logic [N_BTN-1:0] BUTTONS_LEVEL;

  modport master (output BUTTONS_RAW, input BUTTONS, input BUTTONS_LEVEL);
  modport slave  (input BUTTONS_RAW, output BUTTONS, output BUTTONS_LEVEL);
endinterface

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one push-button channel.
//   2-flop synchroniser -> saturating debounce counter -> 4-state FSM,
//   plus the armed flag that suppresses pulses for a button held through
//   reset. Optional auto-repeat when BUTTON_AUTOREPEAT_EN is defined.
// Ports:
//   CLK, RESETN : clock, asynchronous active-low reset
//   btn_raw     : raw pin level
//   btn_pulse   : registered one-cycle press (and repeat) pulse
//   btn_level   : debounced held level
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  logic       sync_p0, sync_p1;
  btn_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic       armed, armed_nxt;
  logic       pulse_nxt;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP = CW'(REPEAT_PERIOD);
  logic [CW-1:0] rcnt, rcnt_nxt, rcnt_inc, rep_thr;
  logic          rep_first, rep_first_nxt;

  assign rcnt_inc = (rcnt == '1) ? rcnt : rcnt + 1'b1;
  assign rep_thr  = rep_first ? RD : RP;
`endif

  assign cnt_inc   = (cnt == DB_MAX) ? cnt : cnt + 1'b1;
  assign btn_level = (state == HELD) || (state == RELEASE_WAIT);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      state     <= RELEASED;
      cnt       <= '0;
      armed     <= 1'b0;
      btn_pulse <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rcnt      <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      // stage p0/p1: metastability synchroniser
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      // FSM and counters act on the synchronised level
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      armed     <= armed_nxt;
      btn_pulse <= pulse_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
      rcnt      <= rcnt_nxt;
      rep_first <= rep_first_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed;
    pulse_nxt = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    rcnt_nxt      = rcnt;
    rep_first_nxt = rep_first;
`endif
    case (state)
      RELEASED: begin
`ifdef BUTTON_AUTOREPEAT_EN
        rcnt_nxt      = '0;
        rep_first_nxt = 1'b1;
`endif
        if (sync_p1) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end else begin
          // A full debounce interval of released input counts as an
          // accepted release, which arms the channel after reset. A button
          // held through reset only shows the reset-cleared synchroniser
          // zeros for two cycles, far short of this.
          cnt_nxt = cnt_inc;
          if (cnt_inc == DB_MAX) armed_nxt = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!sync_p1) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt_inc == DB_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          pulse_nxt = armed;
`ifdef BUTTON_AUTOREPEAT_EN
          rcnt_nxt      = '0;
          rep_first_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!sync_p1) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (rcnt_inc == rep_thr) begin
          pulse_nxt     = armed;
          rcnt_nxt      = '0;
          rep_first_nxt = 1'b0;
        end else begin
          rcnt_nxt = rcnt_inc;
        end
`endif
      end
      RELEASE_WAIT: begin
        // repeat counter deliberately untouched here: a bounce back to HELD
        // resumes the repeat cadence where it left off
        if (sync_p1) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_inc == DB_MAX) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
          armed_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions N_BTN raw push-button levels into clean
// one-cycle press pulses and debounced levels, one independent channel each.
// Optional feature macro: BUTTON_AUTOREPEAT_EN (auto-repeat while held).
// Ports:
//   CLK    : system clock
//   RESETN : asynchronous active-low reset
//   btn    : button_conditioner_if.slave (BUTTONS_RAW in; BUTTONS,
//            BUTTONS_LEVEL out)
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  button_conditioner_if.slave  btn
);

  logic [N_BTN-1:0] pulse_w;
  logic [N_BTN-1:0] level_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .btn_raw  (btn.BUTTONS_RAW[i]),
      .btn_pulse(pulse_w[i]),
      .btn_level(level_w[i])
    );
  end

  assign btn.BUTTONS       = pulse_w;
  assign btn.BUTTONS_LEVEL = level_w;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed bench for button_conditioner with default
// parameters (DEBOUNCE_CYCLES=20, REPEAT_DELAY=500, REPEAT_PERIOD=100).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. "cyc" counts rising edges, so a raw change written when
// cyc==c is sampled at edge c+1 and its press pulse is seen at cyc==c+23.
module tb_button_conditioner;
  localparam int NB = 5;
  localparam int DB = 20;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int LONG_PULSES = 6;
  localparam int LONG_LAST   = 23 + 900;
`else
  localparam int LONG_PULSES = 1;
  localparam int LONG_LAST   = 23;
`endif

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  button_conditioner_if #(.N_BTN(NB)) bif();

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(500), .REPEAT_PERIOD(100)
  ) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .btn   (bif)
  );

  int cyc = 0;
  int pcnt  [NB] = '{default: 0};
  int plast [NB] = '{default: 0};
  int checks = 0;
  int errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    for (int i = 0; i < NB; i++)
      if (bif.BUTTONS[i] === 1'b1) begin
        pcnt[i]  <= pcnt[i] + 1;
        plast[i] <= cyc;
      end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic goto(input int t);
    do @(negedge CLK); while (cyc < t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, b, b1, b3;
    bif.BUTTONS_RAW = '0;
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_buttons", bif.BUTTONS, 0);
    check("reset_level", bif.BUTTONS_LEVEL, 0);
    step();
    RESETN = 1'b1;
    repeat (30) step();

    // clean press on channel 2, with a short low glitch while held
    c = cyc; b = pcnt[2];
    bif.BUTTONS_RAW[2] = 1'b1;
    goto(c + 22);
    check("press_pre_pulse", bif.BUTTONS, 0);
    check("press_pre_level", bif.BUTTONS_LEVEL, 0);
    goto(c + 23);
    check("press_pulse", bif.BUTTONS, 5'b00100);
    check("press_level", bif.BUTTONS_LEVEL, 5'b00100);
    goto(c + 24);
    check("press_width", bif.BUTTONS, 0);
    step_to(c + 50);
    bif.BUTTONS_RAW[2] = 1'b0;
    repeat (3) step();
    bif.BUTTONS_RAW[2] = 1'b1;
    goto(c + 58);
    check("glitch_level", bif.BUTTONS_LEVEL, 5'b00100);
    step_to(c + 100);
    bif.BUTTONS_RAW[2] = 1'b0;
    r = cyc;
    goto(r + 22);
    check("release_pre_level", bif.BUTTONS_LEVEL, 5'b00100);
    goto(r + 23);
    check("release_level", bif.BUTTONS_LEVEL, 0);
    check("press_count", pcnt[2] - b, 1);
    check("press_when", plast[2], c + 23);

    // bouncing channel 0: 12 segments of 5 cycles, then held high
    repeat (10) step();
    c = cyc; b = pcnt[0];
    for (int i = 0; i < 12; i++) begin
      bif.BUTTONS_RAW[0] = (i % 2 == 0);
      repeat (5) step();
    end
    bif.BUTTONS_RAW[0] = 1'b1;
    r = cyc;
    goto(r + 22);
    check("bounce_quiet", pcnt[0] - b, 0);
    check("bounce_level_quiet", bif.BUTTONS_LEVEL, 0);
    goto(r + 23);
    check("bounce_pulse", bif.BUTTONS, 5'b00001);
    goto(r + 30);
    check("bounce_count", pcnt[0] - b, 1);
    step();
    bif.BUTTONS_RAW[0] = 1'b0;
    repeat (40) step();

    // simultaneous channels 1 and 3
    c = cyc;
    bif.BUTTONS_RAW = 5'b01010;
    goto(c + 23);
    check("simul_pulse", bif.BUTTONS, 5'b01010);
    goto(c + 24);
    check("simul_width", bif.BUTTONS, 0);
    check("simul_level", bif.BUTTONS_LEVEL, 5'b01010);
    step();
    bif.BUTTONS_RAW = '0;
    repeat (40) step();

    // long hold on channel 0 for 1000 cycles
    c = cyc; b = pcnt[0];
    bif.BUTTONS_RAW[0] = 1'b1;
    step_to(c + 1000);
    bif.BUTTONS_RAW[0] = 1'b0;
    repeat (40) step();
    check("long_count", pcnt[0] - b, LONG_PULSES);
    check("long_last", plast[0], c + LONG_LAST);

    // channel 4 held through reset
    bif.BUTTONS_RAW[4] = 1'b1;
    repeat (30) step();
    check("hold_pre_reset_level", bif.BUTTONS_LEVEL, 5'b10000);
    RESETN = 1'b0;
    #1;
    check("hold_reset_level", bif.BUTTONS_LEVEL, 0);
    check("hold_reset_buttons", bif.BUTTONS, 0);
    repeat (3) step();
    RESETN = 1'b1;
    b = pcnt[4];
    repeat (200) step();
    check("hold_no_pulse", pcnt[4] - b, 0);
    check("hold_level_follows", bif.BUTTONS_LEVEL, 5'b10000);
    bif.BUTTONS_RAW[4] = 1'b0;
    repeat (40) step();
    check("hold_released_level", bif.BUTTONS_LEVEL, 0);
    c = cyc;
    bif.BUTTONS_RAW[4] = 1'b1;
    goto(c + 23);
    check("hold_repress_pulse", bif.BUTTONS, 5'b10000);
    goto(c + 30);
    check("hold_repress_count", pcnt[4] - b, 1);
    step();
    bif.BUTTONS_RAW[4] = 1'b0;
    repeat (40) step();

    // reset during PRESS_WAIT on channel 3 while channel 1 is held
    bif.BUTTONS_RAW[1] = 1'b1;
    repeat (30) step();
    c = cyc;
    bif.BUTTONS_RAW[3] = 1'b1;
    step_to(c + 13);
    RESETN = 1'b0;
    #1;
    check("middb_reset_level", bif.BUTTONS_LEVEL, 0);
    check("middb_reset_buttons", bif.BUTTONS, 0);
    repeat (3) step();
    RESETN = 1'b1;
    b1 = pcnt[1]; b3 = pcnt[3];
    repeat (100) step();
    check("middb_no_pulse1", pcnt[1] - b1, 0);
    check("middb_no_pulse3", pcnt[3] - b3, 0);
    check("middb_level", bif.BUTTONS_LEVEL, 5'b01010);
    bif.BUTTONS_RAW = '0;
    repeat (40) step();
    c = cyc;
    bif.BUTTONS_RAW[3] = 1'b1;
    goto(c + 23);
    check("middb_repress_pulse", bif.BUTTONS, 5'b01000);
    goto(c + 30);
    check("middb_repress_count", pcnt[3] - b3, 1);
    step();
    bif.BUTTONS_RAW = '0;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
